// File: rtl/branch_hazard_unit_pkg.sv
// Shared types and helpers for the ID-stage branch hazard unit: FSM state
// encoding, stall-depth constants and the per-operand hazard-depth function.
package branch_hazard_unit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } bhu_state_t;

    localparam logic [4:0] REG_ZERO   = 5'd0;

    localparam logic [1:0] STALL_NONE = 2'd0;
    localparam logic [1:0] STALL_ONE  = 2'd1;
    localparam logic [1:0] STALL_TWO  = 2'd2;

    // Cycles a beq operand must wait. An EX producer wins over a MEM producer
    // because it holds the younger value of the register.
    function automatic logic [1:0] operandDepth(
        input logic [4:0] src,
        input logic [4:0] exRw,
        input logic       exRegWr,
        input logic       exMemtoReg,
        input logic [4:0] memRw,
        input logic       memRegWr,
        input logic       memMemtoReg
    );
        logic [1:0] depth;
        depth = STALL_NONE;
        if (src != REG_ZERO) begin
            if (exRegWr && (exRw != REG_ZERO) && (exRw == src)) begin
                depth = exMemtoReg ? STALL_TWO : STALL_ONE;
            end else if (memRegWr && memMemtoReg && (memRw != REG_ZERO) && (memRw == src)) begin
                depth = STALL_ONE;
            end
        end
        return depth;
    endfunction

    function automatic logic [1:0] maxDepth(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/branch_hazard_unit_if.sv
// Pipeline-side signal bundle for branch_hazard_unit: ID operands, forward
// selects, EX/MEM destination info, and the stall/flush controls returned.
interface branch_hazard_unit_if #(
    parameter int DW = 32
);
    logic          id_Branch;
    logic [4:0]    id_Ra;
    logic [4:0]    id_Rb;
    logic [DW-1:0] id_busA;
    logic [DW-1:0] id_busB;
    logic [DW-1:0] mem_ALUout;
    logic          BranchForwardA;
    logic          BranchForwardB;
    logic [4:0]    ex_Rw;
    logic          ex_RegWr;
    logic          ex_MemtoReg;
    logic [4:0]    mem_Rw;
    logic          mem_RegWr;
    logic          mem_MemtoReg;

    // Stall contract: pc_write and ifid_write fall together while idex_bubble
    // rises, holding the fetch side and inserting a nop into EX that cycle.
    // branch_taken/ifid_flush are only meaningful in the resolve cycle and are
    // consumed by PC and IF/ID on the following rising edge.
    logic          pc_write;
    logic          ifid_write;
    logic          idex_bubble;
    logic          branch_taken;
    logic          ifid_flush;

    modport master (
        output id_Branch, id_Ra, id_Rb, id_busA, id_busB, mem_ALUout,
        output BranchForwardA, BranchForwardB,
        output ex_Rw, ex_RegWr, ex_MemtoReg,
        output mem_Rw, mem_RegWr, mem_MemtoReg,
        input  pc_write, ifid_write, idex_bubble, branch_taken, ifid_flush
    );

    modport slave (
        input  id_Branch, id_Ra, id_Rb, id_busA, id_busB, mem_ALUout,
        input  BranchForwardA, BranchForwardB,
        input  ex_Rw, ex_RegWr, ex_MemtoReg,
        input  mem_Rw, mem_RegWr, mem_MemtoReg,
        output pc_write, ifid_write, idex_bubble, branch_taken, ifid_flush
    );

endinterface

// File: rtl/branch_hazard_unit_comparator.sv
// Branch operand forward muxes and full-width equality compare; purely
// combinational.
module branch_comparator #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] busA,
    input  logic [DW-1:0] busB,
    input  logic [DW-1:0] memALUout,
    input  logic          forwardA,
    input  logic          forwardB,
    output logic          equal
);
    logic [DW-1:0] opA;
    logic [DW-1:0] opB;

    always_comb begin
        opA   = forwardA ? memALUout : busA;
        opB   = forwardB ? memALUout : busB;
        equal = (opA == opB);
    end

endmodule

// File: rtl/branch_hazard_unit.sv
// ID-stage beq hazard controller and resolver. Optional saturating stall and
// taken-branch counters are built when BRANCH_STATS_EN is defined.
module branch_hazard_unit
    import branch_hazard_unit_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_hazard_unit_if.slave  bus,
    output bhu_state_t           dbgState,
    output logic [1:0]           dbgCount
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]          stall_cycles,
    output logic [15:0]          branches_taken
`endif
);

    bhu_state_t state;
    bhu_state_t nextState;
    logic [1:0] count;
    logic [1:0] nextCount;
    logic [1:0] depthA;
    logic [1:0] depthB;
    logic [1:0] depth;
    logic       stall;
    logic       resolve;
    logic       stallEff;
    logic       resolveEff;
    logic       operandsEqual;

    always_comb begin
        depthA = operandDepth(bus.id_Ra, bus.ex_Rw, bus.ex_RegWr, bus.ex_MemtoReg,
                              bus.mem_Rw, bus.mem_RegWr, bus.mem_MemtoReg);
        depthB = operandDepth(bus.id_Rb, bus.ex_Rw, bus.ex_RegWr, bus.ex_MemtoReg,
                              bus.mem_Rw, bus.mem_RegWr, bus.mem_MemtoReg);
        depth  = maxDepth(depthA, depthB);
    end

    // count holds the stall depth taken on entry and drains toward the resolve.
    always_comb begin
        nextState = state;
        nextCount = count;
        stall     = 1'b0;
        resolve   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.id_Branch) begin
                    if (depth == STALL_NONE) begin
                        resolve = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        nextCount = depth;
                        nextState = (depth == STALL_TWO) ? STALL : RESOLVE;
                    end
                end
            end
            STALL: begin
                stall     = 1'b1;
                nextCount = count - STALL_ONE;
                nextState = RESOLVE;
            end
            RESOLVE: begin
                resolve   = 1'b1;
                nextCount = STALL_NONE;
                nextState = IDLE;
            end
            default: begin
                nextCount = STALL_NONE;
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= STALL_NONE;
        end else begin
            state <= nextState;
            count <= nextCount;
        end
    end

    branch_comparator #(.DW(DW)) u_comparator (
        .busA      (bus.id_busA),
        .busB      (bus.id_busB),
        .memALUout (bus.mem_ALUout),
        .forwardA  (bus.BranchForwardA),
        .forwardB  (bus.BranchForwardB),
        .equal     (operandsEqual)
    );

    // Reset gates the controls directly so a mid-stall reset frees the pipe at once.
    always_comb begin
        stallEff         = stall & rst_n;
        resolveEff       = resolve & rst_n;
        bus.pc_write     = ~stallEff;
        bus.ifid_write   = ~stallEff;
        bus.idex_bubble  = stallEff;
        bus.branch_taken = resolveEff & operandsEqual;
        bus.ifid_flush   = resolveEff & operandsEqual;
        dbgState         = state;
        dbgCount         = count;
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles   <= 16'd0;
            branches_taken <= 16'd0;
        end else begin
            if (stallEff && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (bus.branch_taken && (branches_taken != 16'hFFFF)) begin
                branches_taken <= branches_taken + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed bench for branch_hazard_unit: single-cycle vector table plus
// multi-cycle stall, resolve and reset sequences (BRANCH_STATS_EN optional).
module tb_branch_hazard_unit;
    import branch_hazard_unit_pkg::*;

    logic clk;
    logic rst_n;
    bhu_state_t dbgState;
    logic [1:0] dbgCount;
`ifdef BRANCH_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] branches_taken;
`endif

    int checks = 0;
    int errors = 0;

    branch_hazard_unit_if #(.DW(32)) bus ();

    branch_hazard_unit #(.DW(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbgState (dbgState),
        .dbgCount (dbgCount)
`ifdef BRANCH_STATS_EN
        ,
        .stall_cycles   (stall_cycles),
        .branches_taken (branches_taken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs packed as {pc_write, ifid_write, idex_bubble, branch_taken, ifid_flush}.
    localparam logic [4:0] O_IDLE  = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00100;
    localparam logic [4:0] O_TAKEN = 5'b11011;

    typedef struct {
        logic        br;
        logic [4:0]  ra, rb;
        logic [31:0] a, b, m;
        logic        fa, fb;
        logic [4:0]  exRw;
        logic        exWr, exLd;
        logic [4:0]  memRw;
        logic        memWr, memLd;
        logic [4:0]  exp;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(logic br, logic [4:0] ra, logic [4:0] rb,
                                logic [31:0] a, logic [31:0] b, logic [31:0] m,
                                logic fa, logic fb,
                                logic [4:0] exRw, logic exWr, logic exLd,
                                logic [4:0] memRw, logic memWr, logic memLd,
                                logic [4:0] exp);
        vec_t v;
        v.br = br; v.ra = ra; v.rb = rb; v.a = a; v.b = b; v.m = m;
        v.fa = fa; v.fb = fb; v.exRw = exRw; v.exWr = exWr; v.exLd = exLd;
        v.memRw = memRw; v.memWr = memWr; v.memLd = memLd; v.exp = exp;
        return v;
    endfunction

    task automatic clearInputs();
        bus.id_Branch = 1'b0; bus.id_Ra = 5'd0; bus.id_Rb = 5'd0;
        bus.id_busA = 32'd0; bus.id_busB = 32'd0; bus.mem_ALUout = 32'd0;
        bus.BranchForwardA = 1'b0; bus.BranchForwardB = 1'b0;
        bus.ex_Rw = 5'd0; bus.ex_RegWr = 1'b0; bus.ex_MemtoReg = 1'b0;
        bus.mem_Rw = 5'd0; bus.mem_RegWr = 1'b0; bus.mem_MemtoReg = 1'b0;
    endtask

    task automatic applyVec(input vec_t v);
        bus.id_Branch = v.br; bus.id_Ra = v.ra; bus.id_Rb = v.rb;
        bus.id_busA = v.a; bus.id_busB = v.b; bus.mem_ALUout = v.m;
        bus.BranchForwardA = v.fa; bus.BranchForwardB = v.fb;
        bus.ex_Rw = v.exRw; bus.ex_RegWr = v.exWr; bus.ex_MemtoReg = v.exLd;
        bus.mem_Rw = v.memRw; bus.mem_RegWr = v.memWr; bus.mem_MemtoReg = v.memLd;
    endtask

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {bus.pc_write, bus.ifid_write, bus.idex_bubble, bus.branch_taken, bus.ifid_flush};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkState(input string name, input bhu_state_t exp);
        checks++;
        if (dbgState !== exp) begin
            errors++;
            $display("FAIL %s: state got %0d expected %0d", name, dbgState, exp);
        end
    endtask

    // Move to the next cycle's drive point: rising edge, then falling edge.
    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = mk(0, 5'd1, 5'd2, 32'd0, 32'd0, 32'd0, 0, 0, 5'd1, 1, 1, 5'd0, 0, 0, O_IDLE);
        vecs[1] = mk(1, 5'd4, 5'd5, 32'd9, 32'd9, 32'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, O_TAKEN);
        vecs[2] = mk(1, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 0, 0, 5'd0, 1, 1, 5'd0, 0, 0, O_IDLE);
        vecs[3] = mk(1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 0, 5'd0, 1, 1, 5'd0, 1, 1, O_TAKEN);
        vecs[4] = mk(1, 5'd6, 5'd7, 32'd0, 32'd33, 32'd33, 1, 0, 5'd0, 0, 0, 5'd6, 1, 0, O_TAKEN);
        vecs[5] = mk(1, 5'd6, 5'd7, 32'd0, 32'd0, 32'd0, 0, 0, 5'd0, 0, 0, 5'd7, 1, 1, O_STALL);
        vecs[6] = mk(1, 5'd8, 5'd9, 32'd5, 32'd6, 32'd5, 0, 1, 5'd9, 0, 1, 5'd0, 0, 0, O_TAKEN);
        vecs[7] = mk(1, 5'd10, 5'd10, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, O_IDLE);
        vecs[8] = mk(1, 5'd3, 5'd12, 32'd0, 32'd0, 32'd0, 0, 0, 5'd12, 1, 1, 5'd0, 0, 0, O_STALL);

        rst_n = 1'b0;
        clearInputs();
        #2;
        check("reset_outputs", O_IDLE);
        checkState("reset_state", IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // add $1 in EX, beq $1,$2: one stall, then forwarded compare taken.
        bus.id_Branch = 1'b1; bus.id_Ra = 5'd1; bus.id_Rb = 5'd2;
        bus.ex_Rw = 5'd1; bus.ex_RegWr = 1'b1;
        #2 check("s1_stall", O_STALL);
        nextCycle();
        clearInputs();
        bus.id_Branch = 1'b1; bus.id_Ra = 5'd1; bus.id_Rb = 5'd2;
        bus.mem_Rw = 5'd1; bus.mem_RegWr = 1'b1;
        bus.BranchForwardA = 1'b1; bus.mem_ALUout = 32'd5; bus.id_busB = 32'd5;
        #2 check("s1_resolve", O_TAKEN);
        nextCycle();
        clearInputs();
        #2 check("s1_after", O_IDLE);
        nextCycle();

        // lw $1 in EX, beq $2,$1: two stalls, then not taken.
        bus.id_Branch = 1'b1; bus.id_Ra = 5'd2; bus.id_Rb = 5'd1;
        bus.ex_Rw = 5'd1; bus.ex_RegWr = 1'b1; bus.ex_MemtoReg = 1'b1;
        #2 check("s2_stall1", O_STALL);
        nextCycle();
        clearInputs();
        bus.id_Branch = 1'b1; bus.id_Ra = 5'd2; bus.id_Rb = 5'd1;
        bus.mem_Rw = 5'd1; bus.mem_RegWr = 1'b1; bus.mem_MemtoReg = 1'b1;
        #2 check("s2_stall2", O_STALL);
        nextCycle();
        clearInputs();
        bus.id_Branch = 1'b1; bus.id_Ra = 5'd2; bus.id_Rb = 5'd1;
        bus.id_busA = 32'd3; bus.id_busB = 32'd4;
        #2 check("s2_resolve", O_IDLE);
        checkState("s2_state", RESOLVE);
        nextCycle();
        clearInputs();

        // lw $3 in MEM, beq $3,$3: exactly one stall, then taken.
        bus.id_Branch = 1'b1; bus.id_Ra = 5'd3; bus.id_Rb = 5'd3;
        bus.mem_Rw = 5'd3; bus.mem_RegWr = 1'b1; bus.mem_MemtoReg = 1'b1;
        #2 check("s3_stall", O_STALL);
        nextCycle();
        clearInputs();
        bus.id_Branch = 1'b1; bus.id_Ra = 5'd3; bus.id_Rb = 5'd3;
        bus.id_busA = 32'd7; bus.id_busB = 32'd7;
        #2 check("s3_resolve", O_TAKEN);
        nextCycle();
        clearInputs();

`ifdef BRANCH_STATS_EN
        checks++;
        if (stall_cycles !== 16'd4) begin
            errors++;
            $display("FAIL stats_stall_cycles: got %0d expected 4", stall_cycles);
        end
        checks++;
        if (branches_taken !== 16'd2) begin
            errors++;
            $display("FAIL stats_branches_taken: got %0d expected 2", branches_taken);
        end
`endif

        // Single-cycle evaluations from IDLE; drain with id_Branch low after each.
        for (int i = 0; i < 9; i++) begin
            applyVec(vecs[i]);
            #2 check($sformatf("vec%0d", i), vecs[i].exp);
            nextCycle();
            clearInputs();
            repeat (2) nextCycle();
        end

        // Reset asserted in STALL forces outputs immediately and returns to IDLE.
        bus.id_Branch = 1'b1; bus.id_Ra = 5'd1; bus.id_Rb = 5'd2;
        bus.ex_Rw = 5'd1; bus.ex_RegWr = 1'b1; bus.ex_MemtoReg = 1'b1;
        #2 check("rst_pre_stall", O_STALL);
        nextCycle();
        #2 checkState("rst_in_stall", STALL);
        rst_n = 1'b0;
        #1 check("rst_outputs", O_IDLE);
        checkState("rst_state", IDLE);
        checks++;
        if (dbgCount !== 2'd0) begin
            errors++;
            $display("FAIL rst_count: got %0d expected 0", dbgCount);
        end
        nextCycle();
        rst_n = 1'b1;
        clearInputs();
        bus.id_Branch = 1'b1; bus.id_Ra = 5'd4; bus.id_Rb = 5'd5;
        bus.ex_Rw = 5'd4; bus.ex_RegWr = 1'b1;
        #2 check("post_rst_stall", O_STALL);
        nextCycle();
        clearInputs();
        bus.id_Branch = 1'b1; bus.id_Ra = 5'd4; bus.id_Rb = 5'd5;
        bus.id_busA = 32'd11; bus.id_busB = 32'd11;
        #2 check("post_rst_resolve", O_TAKEN);
        nextCycle();
        clearInputs();
        #2 check("post_rst_idle", O_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_hazard_unit.md
# branch_hazard_unit

ID-stage branch hazard controller and branch resolver for the 5-stage lw/beq pipeline. It is the direct consumer of the branch forwarding unit's `BranchForwardA`/`BranchForwardB` selects. It detects when a `beq` in ID depends on a result not yet forwardable, stalls PC and IF/ID, and injects ID/EX bubbles for the required number of cycles. It then compares the forwarded operands and drives branch-taken and IF/ID flush.

## Interface
Parameters:
- `DW`, 32: datapath width.

Ports:
- `clk` input 1: pipeline clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `id_Branch` input 1: instruction in ID is `beq`.
- `id_Ra`, `id_Rb` input 5: `beq` source registers.
- `id_busA`, `id_busB` input DW: register-file read data.
- `mem_ALUout` input DW: MEM-stage ALU result (forward source).
- `BranchForwardA`, `BranchForwardB` input 1: forwarding selects, 1 = use `mem_ALUout`.
- `ex_Rw` input 5, `ex_RegWr` input 1, `ex_MemtoReg` input 1: EX-stage destination info.
- `mem_Rw` input 5, `mem_RegWr` input 1, `mem_MemtoReg` input 1: MEM-stage destination info.
- `pc_write` output 1: PC write enable.
- `ifid_write` output 1: IF/ID write enable.
- `idex_bubble` output 1: zero ID/EX control fields.
- `branch_taken` output 1: select branch target into PC.
- `ifid_flush` output 1: clear IF/ID on next edge.

## Operation
- Hazard depth n, computed per operand (Ra, Rb). The overall n is the max over both operands:
  - EX match (`ex_RegWr` & `ex_Rw`≠0 & `ex_Rw`==reg): n=2 if `ex_MemtoReg`, else n=1.
  - Otherwise, MEM load match (`mem_RegWr` & `mem_MemtoReg` & `mem_Rw`≠0 & `mem_Rw`==reg): n=1.
  - Otherwise n=0.
- Register 0 never causes a hazard.
- States: IDLE, STALL, RESOLVE. A 2-bit count register records the stall depth.
- IDLE:
  - `id_Branch`=0: no action.
  - `id_Branch`=1 and n=0: resolve this cycle; stay in IDLE.
  - n>0: stall this cycle. Next state is STALL if n=2, RESOLVE if n=1.
- STALL: stall; next state RESOLVE.
- RESOLVE: no stall; hazard detection suppressed; resolve; next state IDLE.
- Stall means `pc_write`=0, `ifid_write`=0, `idex_bubble`=1. Otherwise these are 1/1/0.
- Resolve:
  - opA = `BranchForwardA` ? `mem_ALUout` : `id_busA`; opB likewise with `BranchForwardB` and `id_busB`.
  - `branch_taken` = (opA==opB), full DW-bit unsigned equality.
  - `ifid_flush` = `branch_taken`.
- Outside a resolve cycle, `branch_taken`=`ifid_flush`=0.
- The register file writes in the first half-cycle and reads in the second, so WB-stage producers need no stall.

## Timing
- All outputs are combinational from state and inputs; state and count update on the rising `clk` edge.
- Stall lengths: 0, 1 or 2 cycles; the branch resolves in the cycle after the last stall.
- The PC/IF/ID consume `branch_taken`/`ifid_flush` on the following edge.
- Reset (`rst_n` low, asynchronous, may occur mid-stall):
  - state=IDLE, count=0.
  - Outputs are forced to `pc_write`=1, `ifid_write`=1, `idex_bubble`=0, `branch_taken`=0, `ifid_flush`=0 while reset is low.
  - The first rising edge after release evaluates from IDLE.

## Configuration
- `BRANCH_STATS_EN` defined:
  - Adds output `stall_cycles` (16) and output `branches_taken` (16).
  - Both are saturating counters (hold at 16'hFFFF) that increment once per stall cycle and once per taken resolve respectively.
  - Both reset to 0.
- Undefined: the counters and their ports are absent; behaviour is otherwise identical.

## Structure
- Shared package holds:
  - state enum `bhu_state_t` {IDLE, STALL, RESOLVE}.
  - `REG_ZERO`=5'd0.
  - stall-depth constants `STALL_NONE`/`STALL_ONE`/`STALL_TWO`.
- Sub-module `branch_comparator`: the two forward muxes and the equality compare. It is purely combinational and instantiated once.

## Test plan
- `add $1` in EX, `beq $1,$2` in ID, non-load → one stall cycle (`pc_write`=0, `idex_bubble`=1). Then RESOLVE with `BranchForwardA`=1, `mem_ALUout`=5, `id_busB`=5 → `branch_taken`=`ifid_flush`=1.
- `lw $1` in EX, `beq $2,$1` → two stall cycles. RESOLVE with `id_busA`=3, `id_busB`=4 → `branch_taken`=0.
- `lw $3` in MEM, `beq $3,$3` in ID → exactly one stall, then taken.
- `beq` with no matching producers (`ex_Rw`=0 with `ex_RegWr`=1 included) → zero stalls, resolves the same cycle.
- Assert `rst_n` low during STALL → outputs at reset values immediately. The next branch after release starts from IDLE.
- With `BRANCH_STATS_EN` defined, run scenarios 1–3 → `stall_cycles`=4, `branches_taken`=2.
